fas_arbiter: RTL

- Round-robin scheduler that shares one external N-bit adder-subtractor (D=0: S=A+B; D=1: S=A-B) among NREQ requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the shared unit's D/A/B inputs from registered operands.
- Captures S/Cout and returns them, tagged with the requester ID, over a valid/ready response channel.
- Sits between client queues and the single shared arithmetic unit.

---
 rtl/fas_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fas_arbiter.sv
// rtl/fas_arbiter.sv - round-robin scheduler sharing one external adder-subtractor among NREQ requesters
// Optional feature macro: FAS_ARB_OVF_EN (adds rsp_ovf signed-overflow flag)
module fas_arbiter #(
    parameter int N    = 10,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              fas_d,
    output logic [N-1:0]      fas_a,
    output logic [N-1:0]      fas_b,
    input  logic [N-1:0]      fas_s,
    input  logic              fas_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_s,
    output logic              rsp_cout
`ifdef FAS_ARB_OVF_EN
    ,
    output logic              rsp_ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic            fas_d_q, fas_d_d;
    logic [N-1:0]    fas_a_q, fas_a_d;
    logic [N-1:0]    fas_b_q, fas_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [N-1:0]    rsp_s_q, rsp_s_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic            ovf_now;

    // Grant search result: first valid requester at or after the rr pointer, with wrap.
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    scan;

    // Round-robin search over all requesters starting at rr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[scan[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IDW-1:0];
            end
        end
    end

    // Signed overflow of the shared unit's current result, judged from the registered operands.
    always_comb begin
        ovf_now = 1'b0;
        if (fas_d_q) begin
            ovf_now = (fas_a_q[N-1] != fas_b_q[N-1]) && (fas_s[N-1] != fas_a_q[N-1]);
        end else begin
            ovf_now = (fas_a_q[N-1] == fas_b_q[N-1]) && (fas_s[N-1] != fas_a_q[N-1]);
        end
    end

`ifdef FAS_ARB_OVF_EN
    logic rsp_ovf_q, rsp_ovf_d;
`endif

    // Next-state and datapath update for the IDLE -> ISSUE -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        fas_d_d     = fas_d_q;
        fas_a_d     = fas_a_q;
        fas_b_d     = fas_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_cout_d  = rsp_cout_q;
`ifdef FAS_ARB_OVF_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        req_ready   = '0;
        unique case (state_q)
            S_IDLE: begin
                // Gated by rst_n so no accept strobe leaks out while reset is held.
                if (grant_found && rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                    fas_d_d  = req_sub[grant_idx];
                    fas_a_d  = req_a[int'(grant_idx)*N +: N];
                    fas_b_d  = req_b[int'(grant_idx)*N +: N];
                    rsp_id_d = grant_idx;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rsp_s_d     = fas_s;
                rsp_cout_d  = fas_cout;
                rsp_valid_d = 1'b1;
`ifdef FAS_ARB_OVF_EN
                rsp_ovf_d   = ovf_now;
`endif
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_d        = (rsp_id_q == IDW'(NREQ-1)) ? '0 : rsp_id_q + IDW'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            fas_d_q     <= 1'b0;
            fas_a_q     <= '0;
            fas_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            fas_d_q     <= fas_d_d;
            fas_a_q     <= fas_a_d;
            fas_b_q     <= fas_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

`ifdef FAS_ARB_OVF_EN
    // Overflow flag register, captured in ISSUE together with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf_q <= 1'b0;
        end else begin
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_now;
`endif

    assign fas_d     = fas_d_q;
    assign fas_a     = fas_a_q;
    assign fas_b     = fas_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_cout  = rsp_cout_q;

endmodule
